// File: rtl/mem_loader_pkg.sv
// Shared constants, state encoding and range helper for the memory preload/verify engine.
package mem_loader_pkg;

    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned MODE_W    = 2;
    localparam int unsigned ERR_W     = 2;

    localparam logic [MODE_W-1:0] MODE_LOAD   = 2'b00;
    localparam logic [MODE_W-1:0] MODE_FILL   = 2'b01;
    localparam logic [MODE_W-1:0] MODE_VERIFY = 2'b10;
    localparam logic [MODE_W-1:0] MODE_RSVD   = 2'b11;

    localparam logic [ERR_W-1:0] ERR_NONE     = 2'b00;
    localparam logic [ERR_W-1:0] ERR_RANGE    = 2'b01;
    localparam logic [ERR_W-1:0] ERR_MISMATCH = 2'b10;
    localparam logic [ERR_W-1:0] ERR_MODE     = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_VERIFY,
        ST_DONE,
        ST_ERROR
    } state_e;

    // True when the region [base, base+len) lies inside a depth-word memory.
    function automatic logic region_fits(input logic [31:0] base,
                                         input logic [31:0] len,
                                         input logic [31:0] depth);
        return (33'(base) + 33'(len)) <= 33'(depth);
    endfunction

endpackage

// File: rtl/mem_loader_verify_pipe.sv
// One-deep expected-data register and address delay that line up a host word with
// the memory read data returned one clock after the address was presented.
module loader_verify_pipe #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  pend_q,
    output logic [ADDR_WIDTH-1:0] cmp_addr_q,
    output logic                  mismatch_c
);

    logic                  pend_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic [ADDR_WIDTH-1:0] cmp_addr_d;

    always_comb begin
        pend_d     = push;
        exp_d      = exp_q;
        cmp_addr_d = cmp_addr_q;
        if (push) begin
            exp_d      = push_data;
            cmp_addr_d = push_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q     <= 1'b0;
            exp_q      <= '0;
            cmp_addr_q <= '0;
        end else begin
            pend_q     <= pend_d;
            exp_q      <= exp_d;
            cmp_addr_q <= cmp_addr_d;
        end
    end

    assign mismatch_c = pend_q && (mem_dout != exp_q);

endmodule

// File: rtl/mem_loader.sv
// Memory preload/verify engine: owns the memory port while the core is held in reset,
// runs a LOAD, FILL or VERIFY job, and optionally hands the port back on success.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = MEM_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [MODE_W-1:0]     mode,
    input  logic                  release_req,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [DATA_WIDTH-1:0] fill_value,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  owns_mem,
    output logic                  core_reset_n,
    output logic                  busy,
    output logic                  done,
    output logic [ERR_W-1:0]      err_code,
    output logic [ADDR_WIDTH-1:0] err_addr
);

    localparam int unsigned LEN_W = ADDR_WIDTH + 1;

    state_e                state_q, state_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d, len_q, len_d, cnt_inc;
    logic [ADDR_WIDTH-1:0] base_q, base_d, addr_cur;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic                  rel_q, rel_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic                  owns_mem_q, owns_mem_d, core_reset_n_q, core_reset_n_d;
    logic [ERR_W-1:0]      err_code_q, err_code_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

    logic                  push_c, pend_q, mismatch_c;
    logic [ADDR_WIDTH-1:0] cmp_addr_q;

    assign cnt_inc  = cnt_q + LEN_W'(1);
    assign addr_cur = base_q + ADDR_WIDTH'(cnt_q);

    loader_verify_pipe #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_verify_pipe (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push_c),
        .push_addr  (addr_cur),
        .push_data  (in_data),
        .mem_dout   (mem_dout),
        .pend_q     (pend_q),
        .cmp_addr_q (cmp_addr_q),
        .mismatch_c (mismatch_c)
    );

    // Next-state, memory port and status computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        len_d      = len_q;
        fill_d     = fill_q;
        rel_d      = rel_q;
        err_code_d = err_code_q;
        err_addr_d = err_addr_q;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_din    = '0;
        push_c     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start && !abort) begin
                    base_d     = base_addr;
                    len_d      = length;
                    fill_d     = fill_value;
                    rel_d      = release_req;
                    cnt_d      = '0;
                    err_code_d = ERR_NONE;
                    err_addr_d = '0;
                    if (mode == MODE_RSVD) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_MODE;
                    end else if (!region_fits(32'(base_addr), 32'(length), 32'(DEPTH))) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_RANGE;
                    end else if (length == '0) begin
                        state_d = ST_DONE;
                    end else if (mode == MODE_LOAD) begin
                        state_d = ST_LOAD;
                    end else if (mode == MODE_FILL) begin
                        state_d = ST_FILL;
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        mem_we   = 1'b1;
                        mem_addr = addr_cur;
                        mem_din  = in_data;
                        cnt_d    = cnt_inc;
                        if (cnt_inc == len_q) state_d = ST_DONE;
                    end
                end
            end
            ST_FILL: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    mem_we   = 1'b1;
                    mem_addr = addr_cur;
                    mem_din  = fill_q;
                    cnt_d    = cnt_inc;
                    if (cnt_inc == len_q) state_d = ST_DONE;
                end
            end
            ST_VERIFY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (mismatch_c) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_MISMATCH;
                    err_addr_d = cmp_addr_q;
                end else begin
                    // Reads stop once every word is issued; the last compare then finishes the job.
                    in_ready = (cnt_q != len_q);
                    if (in_valid && in_ready) begin
                        push_c   = 1'b1;
                        mem_addr = addr_cur;
                        cnt_d    = cnt_inc;
                    end else if (pend_q && (cnt_q == len_q)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d         = (state_d == ST_LOAD) || (state_d == ST_FILL) || (state_d == ST_VERIFY);
        done_d         = (state_d == ST_DONE);
        owns_mem_d     = !((state_d == ST_DONE) && rel_d);
        core_reset_n_d = !owns_mem_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            base_q         <= '0;
            len_q          <= '0;
            fill_q         <= '0;
            rel_q          <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            owns_mem_q     <= 1'b1;
            core_reset_n_q <= 1'b0;
            err_code_q     <= ERR_NONE;
            err_addr_q     <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            base_q         <= base_d;
            len_q          <= len_d;
            fill_q         <= fill_d;
            rel_q          <= rel_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            owns_mem_q     <= owns_mem_d;
            core_reset_n_q <= core_reset_n_d;
            err_code_q     <= err_code_d;
            err_addr_q     <= err_addr_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign owns_mem     = owns_mem_q;
    assign core_reset_n = core_reset_n_q;
    assign err_code     = err_code_q;
    assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_mem_loader.sv
// Randomized bench for mem_loader: a job-level reference model predicts every output
// each cycle, and directed scenarios pin latencies, error codes and memory contents.
module tb_mem_loader;
    import mem_loader_pkg::*;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int D = int'(MEM_DEPTH);

    logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0, release_req = 1'b0;
    logic          abort = 1'b0, in_valid = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic [DW-1:0] fill_value = '0, in_data = '0;
    logic          in_ready, mem_we, owns_mem, core_reset_n, busy, done;
    logic [AW-1:0] mem_addr, err_addr;
    logic [DW-1:0] mem_din, mem_dout;
    logic [1:0]    err_code;

    logic [DW-1:0] mem [D];
    logic [DW-1:0] ref_mem [D];
    logic          clr_mem = 1'b1;
    int            we_count = 0;
    int            n_checks = 0, n_fail = 0;

    // Reference model: job-level view of what the loader is doing.
    int            m_job = 0;   // 0 none, 1 load, 2 fill, 3 verify
    int            m_fin = 0;   // 0 nothing finished, 1 success, 2 error
    logic [1:0]    m_err = 0;
    int            m_eaddr = 0, m_base = 0, m_len = 0, m_pos = 0, m_paddr = 0;
    logic [DW-1:0] m_fv = 0, m_pexp = 0;
    bit            m_rel = 0, m_pend = 0;

    always #5 clk = ~clk;

    mem_loader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .release_req(release_req),
        .abort(abort), .base_addr(base_addr), .length(length), .fill_value(fill_value),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .owns_mem(owns_mem),
        .core_reset_n(core_reset_n), .busy(busy), .done(done), .err_code(err_code),
        .err_addr(err_addr)
    );

    // Synchronous-write, registered-read memory behind the loader port.
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < D; i++) mem[i] <= '0;
        end else begin
            if (mem_we && int'(mem_addr) < D) begin
                mem[mem_addr] <= mem_din;
                we_count <= we_count + 1;
            end
            if (int'(mem_addr) < D) mem_dout <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model across the coming edge.
    always @(negedge clk) begin
        int e_rdy, e_we, e_acc, e_addr, e_din;
        bit mism;
        if (clr_mem) for (int i = 0; i < D; i++) ref_mem[i] = '0;
        if (!reset_n) begin
            m_job = 0; m_fin = 0; m_err = 0; m_eaddr = 0; m_pend = 0; m_rel = 0;
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_din", mem_din, 0);
        end
        mism = (m_job == 3) && m_pend && (ref_mem[m_paddr] != m_pexp);
        e_rdy = 0; e_we = 0; e_acc = 0; e_addr = 0; e_din = 0;
        if (reset_n && !abort) begin
            case (m_job)
                1: begin
                    e_rdy = 1;
                    if (in_valid) begin e_acc = 1; e_we = 1; e_addr = m_base + m_pos; e_din = int'(in_data); end
                end
                2: begin e_acc = 1; e_we = 1; e_addr = m_base + m_pos; e_din = int'(m_fv); end
                3: begin
                    e_rdy = (m_pos < m_len && !mism) ? 1 : 0;
                    if (e_rdy == 1 && in_valid) begin e_acc = 1; e_addr = m_base + m_pos; end
                end
                default: ;
            endcase
        end
        chk("in_ready", in_ready, e_rdy);
        chk("mem_we", mem_we, e_we);
        if (e_acc == 1) chk("mem_addr", mem_addr, e_addr);
        if (e_we == 1) chk("mem_din", mem_din, e_din);
        chk("busy", busy, m_job != 0);
        chk("done", done, m_job == 0 && m_fin == 1);
        chk("owns_mem", owns_mem, !(m_job == 0 && m_fin == 1 && m_rel));
        chk("core_reset_n", core_reset_n, m_job == 0 && m_fin == 1 && m_rel);
        chk("err_code", err_code, m_err);
        chk("err_addr", err_addr, m_eaddr);
        if (reset_n) begin
            if (abort && m_job != 0) begin
                m_job = 0; m_fin = 0; m_pend = 0;
            end else if (m_job == 0) begin
                if (start && !abort) begin
                    m_err = 0; m_eaddr = 0; m_fin = 0; m_pos = 0; m_pend = 0;
                    m_base = int'(base_addr); m_len = int'(length); m_fv = fill_value; m_rel = release_req;
                    if (mode == 2'd3) begin m_err = 2'd3; m_fin = 2; end
                    else if (m_base + m_len > D) begin m_err = 2'd1; m_fin = 2; end
                    else if (m_len == 0) m_fin = 1;
                    else m_job = int'(mode) + 1;
                end
            end else if (m_job == 3) begin
                if (mism) begin
                    m_err = 2'd2; m_eaddr = m_paddr; m_job = 0; m_fin = 2; m_pend = 0;
                end else begin
                    m_pend = 0;
                    if (e_acc == 1) begin m_pend = 1; m_pexp = in_data; m_paddr = e_addr; m_pos++; end
                    if (m_pos == m_len && !m_pend) begin m_job = 0; m_fin = 1; end
                end
            end else if (e_acc == 1) begin
                ref_mem[e_addr] = DW'(e_din);
                m_pos++;
                if (m_pos == m_len) begin m_job = 0; m_fin = 1; end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch_job(input logic [1:0] md, input int b, input int len,
                              input logic [DW-1:0] fv, input bit rel);
        mode = md; base_addr = AW'(b); length = (AW+1)'(len); fill_value = fv;
        release_req = rel; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Feed host words while the job runs; gap 0 continuous, 1 alternate, 2 random.
    task automatic run_stream(input logic [DW-1:0] q[$], input int gap, input int abort_at,
                              output int ncyc);
        int i = 0;
        int cyc = 0;
        bit x;
        while (busy && cyc < 4000) begin
            in_valid = (gap == 0) || (gap == 1 && cyc % 2 == 0) || (gap == 2 && $urandom_range(0, 2) != 0);
            in_data  = (i < q.size()) ? q[i] : DW'($urandom);
            abort    = (cyc == abort_at);
            @(negedge clk);
            x = in_valid && in_ready;
            tick();
            if (x) i++;
            cyc++;
            abort = 1'b0;
        end
        in_valid = 1'b0;
        ncyc = cyc;
        chk("job_terminates", busy, 0);
    endtask

    initial begin
        logic [DW-1:0] q[$];
        logic [DW-1:0] v;
        int ncyc, w0, b, ln, nz;
        logic [1:0] md;

        tick(); clr_mem = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // LOAD 4 bytes at 0x10 with release.
        q = '{8'hA9, 8'h01, 8'h8D, 8'h00};
        launch_job(2'b00, 16'h10, 4, 8'h00, 1'b1);
        run_stream(q, 0, -1, ncyc);
        chk("load_latency", ncyc + 1, 5);
        chk("load_m10", mem[16'h10], 8'hA9);
        chk("load_m11", mem[16'h11], 8'h01);
        chk("load_m12", mem[16'h12], 8'h8D);
        chk("load_m13", mem[16'h13], 8'h00);
        chk("load_done", done, 1);
        chk("load_core_rst", core_reset_n, 1);
        chk("load_owns", owns_mem, 0);
        tick();

        // VERIFY with last byte wrong.
        q = '{8'hA9, 8'h01, 8'h8D, 8'h55};
        launch_job(2'b10, 16'h10, 4, 8'h00, 1'b1);
        run_stream(q, 0, -1, ncyc);
        chk("verify_err", err_code, 2'b10);
        chk("verify_err_addr", err_addr, 16'h0013);
        chk("verify_core_rst", core_reset_n, 0);
        tick();

        // FILL whole memory with zero.
        launch_job(2'b01, 0, D, 8'h00, 1'b0);
        q.delete();
        run_stream(q, 0, -1, ncyc);
        chk("fill_latency", ncyc + 1, D + 1);
        nz = 0;
        for (int i = 0; i < D; i++) if (mem[i] != 8'h00) nz++;
        chk("fill_nonzero_words", nz, 0);

        // RANGE and MODE errors.
        w0 = we_count;
        launch_job(2'b00, D - 2, 3, 8'h00, 1'b1);
        tick(); tick();
        chk("range_err", err_code, 2'b01);
        chk("range_no_write", we_count - w0, 0);
        launch_job(2'b11, 0, 1, 8'h00, 1'b1);
        tick();
        chk("mode_err", err_code, 2'b11);

        // LOAD 8 with in_valid toggling.
        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        w0 = we_count;
        launch_job(2'b00, 16'h40, 8, 8'h00, 1'b0);
        run_stream(q, 1, -1, ncyc);
        chk("gap_writes", we_count - w0, 8);
        for (int i = 0; i < 8; i++) chk("gap_data", mem[16'h40 + i], q[i]);

        // Abort after 3 of 8 LOAD words.
        q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8};
        w0 = we_count;
        launch_job(2'b00, 16'h80, 8, 8'h00, 1'b1);
        run_stream(q, 0, 3, ncyc);
        chk("abort_writes", we_count - w0, 3);
        chk("abort_done", done, 0);
        chk("abort_m82", mem[16'h82], 8'hC3);
        chk("abort_m83", mem[16'h83], 8'h00);
        tick();

        // Asynchronous reset in the middle of a FILL.
        launch_job(2'b01, 0, 100, 8'h5A, 1'b1);
        tick(); tick(); tick(); tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 0);
        chk("arst_mem_we", mem_we, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_mem_din", mem_din, 0);
        chk("arst_owns", owns_mem, 1);
        chk("arst_core_rst", core_reset_n, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err_code, 0);
        chk("arst_err_addr", err_addr, 0);
        chk("arst_m04", mem[4], 8'h5A);
        chk("arst_m05", mem[5], 8'h00);
        tick();
        reset_n = 1'b1;
        tick();

        // Randomized jobs.
        for (int j = 0; j < 40; j++) begin
            md = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            b  = $urandom_range(0, D - 1);
            if ($urandom_range(0, 7) == 0) ln = $urandom_range(0, D);
            else ln = $urandom_range(0, (D - b < 24) ? D - b : 24);
            q.delete();
            for (int i = 0; i < ln; i++) begin
                if (md == 2'b10 && b + i < D) begin
                    v = ref_mem[b + i];
                    if ($urandom_range(0, 15) == 0) v = v ^ 8'h01;
                end else begin
                    v = DW'($urandom);
                end
                q.push_back(v);
            end
            launch_job(md, b, ln, DW'($urandom), 1'($urandom));
            run_stream(q, 2, ($urandom_range(0, 4) == 0) ? $urandom_range(0, ln) : -1, ncyc);
            tick();
        end

        for (int i = 0; i < D; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, limit 2000000 expected finish");
        $fatal(1);
    end

endmodule
